// File: rtl/wb_commit_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_commit_if
//  Description : Bus bundle for the write-back commit buffer: producer
//                handshake, register-file write port and forwarding lookups.
//                The slave modport is the buffer side, master the user side.
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_commit_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Producer side
  logic          in_valid;
  logic          in_ready;
  logic          in_we;
  logic [4:0]    in_rd;
  logic [31:0]   in_wd;
  logic [31:0]   in_pc;

  // Register-file write port
  logic          drain_en;
  logic          rf_we;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_wd;
  logic [31:0]   rf_pc;

  // Forwarding lookups
  logic [4:0]    fwd_a1;
  logic [4:0]    fwd_a2;
  logic          fwd_hit1;
  logic          fwd_hit2;
  logic [31:0]   fwd_d1;
  logic [31:0]   fwd_d2;

  // Occupancy
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, in_we, in_rd, in_wd, in_pc,
    input  drain_en, fwd_a1, fwd_a2,
    output in_ready, rf_we, rf_rd, rf_wd, rf_pc,
    output fwd_hit1, fwd_hit2, fwd_d1, fwd_d2, count
  );

  modport master (
    output in_valid, in_we, in_rd, in_wd, in_pc,
    output drain_en, fwd_a1, fwd_a2,
    input  in_ready, rf_we, rf_rd, rf_wd, rf_pc,
    input  fwd_hit1, fwd_hit2, fwd_d1, fwd_d2, count
  );
endinterface
`default_nettype wire

// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
//  Module      : wb_commit
//  Description : In-order write-back commit buffer. Accepts register
//                write-backs from a producer, holds up to DEPTH of them and
//                drains them in FIFO order to the register-file write port
//                whenever that port is granted. Pending entries are visible
//                to two forwarding lookups (youngest match wins, x0 never
//                hits). Entries that do not write a register are accepted
//                and dropped.
//  Options     : `define WB_COMMIT_TRACE_EN prints one line per retired write
//                at the popping edge; the logic is identical either way.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_commit #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  wb_commit_if.slave     bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Only power-of-two depths from 2 to 16 are legal: pointer wrap relies on
  // natural binary overflow of a PW-bit pointer.
  generate
    if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("wb_commit: DEPTH must be a power of two from 2 to 16");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [4:0]    r_rd [DEPTH];
  logic [31:0]   r_wd [DEPTH];
  logic [31:0]   r_pc [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic w_empty;
  logic w_full;
  logic w_accept;
  logic w_keep;
  logic w_pop;

  assign w_empty  = (r_count == '0);
  // No push-through when full: a simultaneous pop does not open a slot
  // until the following cycle.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_accept = bus.in_valid && !w_full;
  // Non-writing entries and writes to x0 complete the handshake but are not
  // stored.
  assign w_keep   = w_accept && bus.in_we && (bus.in_rd != 5'd0);
  assign w_pop    = bus.drain_en && !w_empty;

  // Capture kept entries into the slot at the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i] <= 5'd0;
        r_wd[i] <= 32'd0;
        r_pc[i] <= 32'd0;
      end
    end else if (w_keep) begin
      r_rd[r_wr_ptr] <= bus.in_rd;
      r_wd[r_wr_ptr] <= bus.in_wd;
      r_pc[r_wr_ptr] <= bus.in_pc;
    end
  end

  // Advance pointers (modulo DEPTH by overflow) and track occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_keep) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_keep, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register-file write port: head entry, zeroed when empty
  // --------------------------------------------------------------------------
  assign bus.in_ready = !w_full;
  assign bus.rf_we    = w_pop;
  assign bus.rf_rd    = w_empty ? 5'd0  : r_rd[r_rd_ptr];
  assign bus.rf_wd    = w_empty ? 32'd0 : r_wd[r_rd_ptr];
  assign bus.rf_pc    = w_empty ? 32'd0 : r_pc[r_rd_ptr];
  assign bus.count    = r_count;

  // --------------------------------------------------------------------------
  // Forwarding. Entries are walked oldest to youngest so the last match
  // seen is the youngest. Only stored entries take part, so the offer on
  // the bus this cycle is invisible, while the head being popped this cycle
  // is still stored and therefore still visible.
  // --------------------------------------------------------------------------
  logic        w_hit1;
  logic        w_hit2;
  logic [31:0] w_d1;
  logic [31:0] w_d2;

  // Lookup port 1: youngest pending entry whose destination matches fwd_a1.
  always_comb begin
    w_hit1 = 1'b0;
    w_d1   = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (bus.fwd_a1 != 5'd0) &&
          (r_rd[r_rd_ptr + PW'(i)] == bus.fwd_a1)) begin
        w_hit1 = 1'b1;
        w_d1   = r_wd[r_rd_ptr + PW'(i)];
      end
    end
  end

  // Lookup port 2: youngest pending entry whose destination matches fwd_a2.
  always_comb begin
    w_hit2 = 1'b0;
    w_d2   = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) && (bus.fwd_a2 != 5'd0) &&
          (r_rd[r_rd_ptr + PW'(i)] == bus.fwd_a2)) begin
        w_hit2 = 1'b1;
        w_d2   = r_wd[r_rd_ptr + PW'(i)];
      end
    end
  end

  assign bus.fwd_hit1 = w_hit1;
  assign bus.fwd_hit2 = w_hit2;
  assign bus.fwd_d1   = w_d1;
  assign bus.fwd_d2   = w_d2;

`ifdef WB_COMMIT_TRACE_EN
  // Report each retiring write at the edge that pops it.
  always @(posedge clk) begin
    if (!reset && w_pop) begin
      $display("@%08h: $%02d <= %08h", bus.rf_pc, bus.rf_rd, bus.rf_wd);
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_commit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_commit
//  Description : Self-checking bench for wb_commit: directed vector table,
//                reset corner sequences and randomized traffic against a
//                queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_commit;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_commit_if #(.DEPTH(DEPTH)) bus ();

  wb_commit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [CW-1:0] count;
    logic          ready;
    logic          we;
    logic [4:0]    rd;
    logic [31:0]   wd;
    logic [31:0]   pc;
    logic          hit1;
    logic [31:0]   d1;
    logic          hit2;
    logic [31:0]   d2;
  } exp_t;

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pc;
    logic        drain;
    logic [4:0]  a1;
    logic [4:0]  a2;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  vec_t vq[$];
  ent_t mq[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic compare(string tag, exp_t e);
    chk({tag, ".count"}, 32'(bus.count), 32'(e.count));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(e.ready));
    chk({tag, ".rf_we"}, 32'(bus.rf_we), 32'(e.we));
    chk({tag, ".rf_rd"}, 32'(bus.rf_rd), 32'(e.rd));
    chk({tag, ".rf_wd"}, bus.rf_wd, e.wd);
    chk({tag, ".rf_pc"}, bus.rf_pc, e.pc);
    chk({tag, ".fwd_hit1"}, 32'(bus.fwd_hit1), 32'(e.hit1));
    chk({tag, ".fwd_d1"}, bus.fwd_d1, e.d1);
    chk({tag, ".fwd_hit2"}, 32'(bus.fwd_hit2), 32'(e.hit2));
    chk({tag, ".fwd_d2"}, bus.fwd_d2, e.d2);
  endtask

  // Reference model: pending entries in a queue, oldest at the front.
  function automatic exp_t model_out(logic drain, logic [4:0] a1, logic [4:0] a2);
    exp_t e;
    e = '{default: '0};
    e.count = CW'(mq.size());
    e.ready = (mq.size() < DEPTH);
    e.we    = drain && (mq.size() != 0);
    if (mq.size() != 0) begin
      e.rd = mq[0].rd;
      e.wd = mq[0].wd;
      e.pc = mq[0].pc;
    end
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (a1 != 0 && mq[i].rd == a1) begin
        e.hit1 = 1'b1;
        e.d1   = mq[i].wd;
        break;
      end
    end
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (a2 != 0 && mq[i].rd == a2) begin
        e.hit2 = 1'b1;
        e.d2   = mq[i].wd;
        break;
      end
    end
    return e;
  endfunction

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    ent_t n;
    bit   acc;
    acc = bus.in_valid && (mq.size() < DEPTH);
    if (bus.drain_en && mq.size() != 0) void'(mq.pop_front());
    if (acc && bus.in_we && bus.in_rd != 0) begin
      n.rd = bus.in_rd;
      n.wd = bus.in_wd;
      n.pc = bus.in_pc;
      mq.push_back(n);
    end
  endtask

  task automatic drive(logic v, logic we, logic [4:0] rd, logic [31:0] wd,
                       logic [31:0] pc, logic drain, logic [4:0] a1, logic [4:0] a2);
    bus.in_valid = v;
    bus.in_we    = we;
    bus.in_rd    = rd;
    bus.in_wd    = wd;
    bus.in_pc    = pc;
    bus.drain_en = drain;
    bus.fwd_a1   = a1;
    bus.fwd_a2   = a2;
  endtask

  // Check outputs mid-cycle, then cross the next rising edge.
  task automatic step_check(string tag, exp_t e);
    @(negedge clk);
    compare(tag, e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic add(logic v, logic we, logic [4:0] rd, logic [31:0] wd, logic [31:0] pc,
                     logic drain, logic [4:0] a1, logic [4:0] a2,
                     int cnt, logic rdy, logic rwe, logic [4:0] rrd, logic [31:0] rwd,
                     logic [31:0] rpc, logic h1, logic [31:0] d1, logic h2, logic [31:0] d2);
    vec_t x;
    x.v = v; x.we = we; x.rd = rd; x.wd = wd; x.pc = pc;
    x.drain = drain; x.a1 = a1; x.a2 = a2;
    x.e.count = CW'(cnt); x.e.ready = rdy; x.e.we = rwe; x.e.rd = rrd;
    x.e.wd = rwd; x.e.pc = rpc; x.e.hit1 = h1; x.e.d1 = d1; x.e.hit2 = h2; x.e.d2 = d2;
    vq.push_back(x);
  endtask

  exp_t ez;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table: inputs | expected outputs sampled before the edge.
    //   v we rd  wd      pc       dr a1 a2 | cnt rdy we rd wd      pc       h1 d1      h2 d2
    add(1,1, 3, 32'h11, 32'h3000, 1, 3, 0,   0, 1, 0, 0, 0,      0,       0, 0,      0, 0);
    add(0,0, 0, 0,      0,        1, 3, 0,   1, 1, 1, 3, 32'h11, 32'h3000,1, 32'h11, 0, 0);
    add(0,0, 0, 0,      0,        0, 3, 0,   0, 1, 0, 0, 0,      0,       0, 0,      0, 0);
    add(1,1, 1, 32'h101,32'h2004, 0, 1, 0,   0, 1, 0, 0, 0,      0,       0, 0,      0, 0);
    add(1,1, 2, 32'h102,32'h2008, 0, 1, 0,   1, 1, 0, 1, 32'h101,32'h2004,1, 32'h101,0, 0);
    add(1,1, 3, 32'h103,32'h200C, 0, 2, 1,   2, 1, 0, 1, 32'h101,32'h2004,1, 32'h102,1, 32'h101);
    add(1,1, 4, 32'h104,32'h2010, 0, 4, 2,   3, 1, 0, 1, 32'h101,32'h2004,0, 0,      1, 32'h102);
    add(1,1, 9, 32'h109,32'h2024, 0, 4, 3,   4, 0, 0, 1, 32'h101,32'h2004,1, 32'h104,1, 32'h103);
    add(1,1, 9, 32'h109,32'h2024, 0, 9, 0,   4, 0, 0, 1, 32'h101,32'h2004,0, 0,      0, 0);
    add(1,1, 9, 32'h109,32'h2024, 1, 1, 0,   4, 0, 1, 1, 32'h101,32'h2004,1, 32'h101,0, 0);
    add(1,1, 9, 32'h109,32'h2024, 1, 9, 2,   3, 1, 1, 2, 32'h102,32'h2008,0, 0,      1, 32'h102);
    add(0,0, 0, 0,      0,        1, 9, 4,   3, 1, 1, 3, 32'h103,32'h200C,1, 32'h109,1, 32'h104);
    add(0,0, 0, 0,      0,        1, 3, 0,   2, 1, 1, 4, 32'h104,32'h2010,0, 0,      0, 0);
    add(0,0, 0, 0,      0,        1, 9, 0,   1, 1, 1, 9, 32'h109,32'h2024,1, 32'h109,0, 0);
    add(0,0, 0, 0,      0,        0, 9, 0,   0, 1, 0, 0, 0,      0,       0, 0,      0, 0);
    add(1,1, 5, 32'hA,  32'h2014, 0, 5, 0,   0, 1, 0, 0, 0,      0,       0, 0,      0, 0);
    add(1,1, 5, 32'hB,  32'h2018, 0, 5, 0,   1, 1, 0, 5, 32'hA,  32'h2014,1, 32'hA,  0, 0);
    add(0,0, 0, 0,      0,        0, 5, 0,   2, 1, 0, 5, 32'hA,  32'h2014,1, 32'hB,  0, 0);
    add(0,0, 0, 0,      0,        1, 5, 5,   2, 1, 1, 5, 32'hA,  32'h2014,1, 32'hB,  1, 32'hB);
    add(0,0, 0, 0,      0,        1, 5, 0,   1, 1, 1, 5, 32'hB,  32'h2018,1, 32'hB,  0, 0);
    add(1,1, 0, 32'hFF, 32'h2000, 1, 0, 0,   0, 1, 0, 0, 0,      0,       0, 0,      0, 0);
    add(1,0, 7, 32'h77, 32'h201C, 1, 7, 0,   0, 1, 0, 0, 0,      0,       0, 0,      0, 0);
    add(0,0, 0, 0,      0,        1, 7, 0,   0, 1, 0, 0, 0,      0,       0, 0,      0, 0);

    ez = '{default: '0};
    ez.ready = 1'b1;

    // Reset state while reset is held.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    reset = 1'b1;
    #3;
    compare("reset", ez);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    mq.delete();

    // Directed vectors.
    foreach (vq[k]) begin
      drive(vq[k].v, vq[k].we, vq[k].rd, vq[k].wd, vq[k].pc, vq[k].drain, vq[k].a1, vq[k].a2);
      step_check($sformatf("vec%0d", k), vq[k].e);
    end

    // Reset mid-operation with two pending entries.
    drive(1, 1, 10, 32'hAAA, 32'h4000, 0, 10, 0);
    step_check("pre_rst0", model_out(0, 10, 0));
    drive(1, 1, 11, 32'hBBB, 32'h4004, 0, 11, 10);
    step_check("pre_rst1", model_out(0, 11, 10));
    drive(0, 0, 0, 0, 0, 1, 10, 11);
    @(negedge clk);
    compare("pre_rst2", model_out(1, 10, 11));
    reset = 1'b1;
    #1;
    chk("midrst.count", 32'(bus.count), 32'd0);
    chk("midrst.rf_we", 32'(bus.rf_we), 32'd0);
    chk("midrst.fwd_hit1", 32'(bus.fwd_hit1), 32'd0);
    mq.delete();
    #4;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      compare($sformatf("post_rst%0d", i), model_out(1, 10, 11));
    end

    // Offer held across an edge while reset is asserted is not accepted.
    @(posedge clk);
    #1;
    drive(1, 1, 12, 32'hCCC, 32'h5000, 0, 12, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_offer.count", 32'(bus.count), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 12, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_offer.count2", 32'(bus.count), 32'd0);
    chk("rst_offer.hit", 32'(bus.fwd_hit1), 32'd0);
    mq.delete();

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      logic        v, we, dr;
      logic [4:0]  rd, a1, a2;
      logic [31:0] wd, pc;
      v  = ($urandom_range(0, 9) < 7);
      we = ($urandom_range(0, 9) < 9);
      rd = 5'($urandom_range(0, 7));
      wd = $urandom;
      pc = $urandom;
      dr = ($urandom_range(0, 9) < (n < 200 ? 4 : 6));
      a1 = 5'($urandom_range(0, 7));
      a2 = 5'($urandom_range(0, 7));
      drive(v, we, rd, wd, pc, dr, a1, a2);
      step_check("rnd", model_out(dr, a1, a2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
